picorv32_freeahb_adapter: RTL and testbench

- Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) to the FreeAHB master user interface (valid/next/ready).
- Each PicoRV32 request becomes exactly one single (non-burst) AHB transfer.
- Sits between the picorv32 core and the FreeAHB master inside the GRLIB RISC-V wrapper.

---
 rtl/picorv32_freeahb_adapter.sv | 136 +++++++++++++
 tb/tb_picorv32_freeahb_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_freeahb_adapter.sv
// picorv32_freeahb_adapter: bridges the PicoRV32 native memory port to the
// FreeAHB master user interface, one single (non-burst) transfer per request.
//
// Ports:
//   clk, resetn            clock; asynchronous reset, active HIGH despite the name
//   mem_valid/instr/addr/wdata/wstrb  PicoRV32 request (wstrb == 0 means read)
//   mem_ready, mem_rdata   one-cycle completion pulse, held read data
//   freeahb_valid/addr/size/write/read/wdata/prot  registered transfer request
//   freeahb_min_len/cont/lock  tied to 0 (single transfers only)
//   freeahb_next           request accepted (completes a write)
//   freeahb_ready/rdata    read data valid (completes a read)
//   freeahb_result_addr    unused
module picorv32_freeahb_adapter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        freeahb_valid,
    output logic [31:0] freeahb_addr,
    output logic [2:0]  freeahb_size,
    output logic        freeahb_write,
    output logic        freeahb_read,
    output logic [31:0] freeahb_wdata,
    output logic [31:0] freeahb_min_len,
    output logic        freeahb_cont,
    output logic [3:0]  freeahb_prot,
    output logic        freeahb_lock,
    input  logic        freeahb_next,
    input  logic        freeahb_ready,
    input  logic [31:0] freeahb_rdata,
    input  logic [31:0] freeahb_result_addr
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        TURN
    } state_t;

    state_t     state;
    logic [2:0] wr_size;
    logic [1:0] wr_off;
    logic       unused_ok;

    assign freeahb_min_len = 32'd0;
    assign freeahb_cont    = 1'b0;
    assign freeahb_lock    = 1'b0;

    // Low address bits come from the strobes, not from the core.
    assign unused_ok = ^{freeahb_result_addr, mem_addr[1:0]};

    // Contiguous byte/halfword strobes map to narrow transfers;
    // anything irregular falls back to a full word at offset 0.
    always_comb begin
        wr_size = 3'b010;
        wr_off  = 2'd0;
        case (mem_wstrb)
            4'b0011: begin wr_size = 3'b001; wr_off = 2'd0; end
            4'b1100: begin wr_size = 3'b001; wr_off = 2'd2; end
            4'b0001: begin wr_size = 3'b000; wr_off = 2'd0; end
            4'b0010: begin wr_size = 3'b000; wr_off = 2'd1; end
            4'b0100: begin wr_size = 3'b000; wr_off = 2'd2; end
            4'b1000: begin wr_size = 3'b000; wr_off = 2'd3; end
            default: begin wr_size = 3'b010; wr_off = 2'd0; end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state         <= IDLE;
            mem_ready     <= 1'b0;
            mem_rdata     <= 32'd0;
            freeahb_valid <= 1'b0;
            freeahb_addr  <= 32'd0;
            freeahb_size  <= 3'd0;
            freeahb_write <= 1'b0;
            freeahb_read  <= 1'b0;
            freeahb_wdata <= 32'd0;
            freeahb_prot  <= 4'd0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        freeahb_valid <= 1'b1;
                        freeahb_wdata <= mem_wdata;
                        freeahb_prot  <= {2'b00, 1'b1, ~mem_instr};
                        if (mem_wstrb == 4'd0) begin
                            freeahb_read  <= 1'b1;
                            freeahb_write <= 1'b0;
                            freeahb_size  <= 3'b010;
                            freeahb_addr  <= {mem_addr[31:2], 2'b00};
                            state         <= READ;
                        end else begin
                            freeahb_read  <= 1'b0;
                            freeahb_write <= 1'b1;
                            freeahb_size  <= wr_size;
                            freeahb_addr  <= {mem_addr[31:2], wr_off};
                            state         <= WRITE;
                        end
                    end
                end
                READ: begin
                    // Reads finish only when data arrives, not on next.
                    if (freeahb_ready) begin
                        mem_rdata     <= freeahb_rdata;
                        freeahb_valid <= 1'b0;
                        freeahb_read  <= 1'b0;
                        mem_ready     <= 1'b1;
                        state         <= TURN;
                    end
                end
                WRITE: begin
                    if (freeahb_next) begin
                        freeahb_valid <= 1'b0;
                        freeahb_write <= 1'b0;
                        mem_ready     <= 1'b1;
                        state         <= TURN;
                    end
                end
                TURN: begin
                    // Gives the core a cycle to drop or change its request.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_freeahb_adapter.sv
// Directed bench for picorv32_freeahb_adapter.
// Drives inputs 1ns after the rising edge and checks outputs there.
module tb_picorv32_freeahb_adapter;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        freeahb_valid;
    logic [31:0] freeahb_addr;
    logic [2:0]  freeahb_size;
    logic        freeahb_write;
    logic        freeahb_read;
    logic [31:0] freeahb_wdata;
    logic [31:0] freeahb_min_len;
    logic        freeahb_cont;
    logic [3:0]  freeahb_prot;
    logic        freeahb_lock;
    logic        freeahb_next;
    logic        freeahb_ready;
    logic [31:0] freeahb_rdata;
    logic [31:0] freeahb_result_addr;

    int checks;
    int failures;

    picorv32_freeahb_adapter dut (
        .clk                (clk),
        .resetn             (resetn),
        .mem_valid          (mem_valid),
        .mem_instr          (mem_instr),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wstrb          (mem_wstrb),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .freeahb_valid      (freeahb_valid),
        .freeahb_addr       (freeahb_addr),
        .freeahb_size       (freeahb_size),
        .freeahb_write      (freeahb_write),
        .freeahb_read       (freeahb_read),
        .freeahb_wdata      (freeahb_wdata),
        .freeahb_min_len    (freeahb_min_len),
        .freeahb_cont       (freeahb_cont),
        .freeahb_prot       (freeahb_prot),
        .freeahb_lock       (freeahb_lock),
        .freeahb_next       (freeahb_next),
        .freeahb_ready      (freeahb_ready),
        .freeahb_rdata      (freeahb_rdata),
        .freeahb_result_addr(freeahb_result_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_valid"}, 32'(freeahb_valid), 32'd0);
        check({tag, "_ready"}, 32'(mem_ready), 32'd0);
        check({tag, "_rdata"}, mem_rdata, 32'd0);
        check({tag, "_addr"}, freeahb_addr, 32'd0);
        check({tag, "_size"}, 32'(freeahb_size), 32'd0);
        check({tag, "_wr"}, 32'(freeahb_write), 32'd0);
        check({tag, "_rd"}, 32'(freeahb_read), 32'd0);
        check({tag, "_wdata"}, freeahb_wdata, 32'd0);
        check({tag, "_prot"}, 32'(freeahb_prot), 32'd0);
        check({tag, "_ties"},
              freeahb_min_len | 32'(freeahb_cont) | 32'(freeahb_lock),
              32'd0);
    endtask

    // Single write from IDLE, accepted immediately, ends back in IDLE.
    task automatic do_write(input string tag, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] ea,
                            input logic [2:0] es);
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = a ^ 32'h5A5A_5A5A;
        tick();
        check({tag, "_addr"}, freeahb_addr, ea);
        check({tag, "_size"}, 32'(freeahb_size), 32'(es));
        check({tag, "_wr"}, 32'(freeahb_write), 32'd1);
        check({tag, "_wdata"}, freeahb_wdata, a ^ 32'h5A5A_5A5A);
        freeahb_next = 1'b1;
        tick();
        check({tag, "_done"}, 32'(mem_ready), 32'd1);
        freeahb_next = 1'b0;
        mem_valid    = 1'b0;
        tick();
        check({tag, "_pulse"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        resetn              = 1'b1;
        mem_valid           = 1'b0;
        mem_instr           = 1'b0;
        mem_addr            = 32'd0;
        mem_wdata           = 32'd0;
        mem_wstrb           = 4'd0;
        freeahb_next        = 1'b0;
        freeahb_ready       = 1'b0;
        freeahb_rdata       = 32'd0;
        freeahb_result_addr = 32'hDEAD_BEEF;

        tick();
        tick();
        all_zero("rst");
        resetn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(freeahb_valid), 32'd0);
        end

        // Word read, completion only on freeahb_ready.
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        mem_wstrb = 4'd0;
        mem_instr = 1'b0;
        tick();
        check("rd_valid", 32'(freeahb_valid), 32'd1);
        check("rd_rd", 32'(freeahb_read), 32'd1);
        check("rd_wr", 32'(freeahb_write), 32'd0);
        check("rd_addr", freeahb_addr, 32'h8000_0000);
        check("rd_size", 32'(freeahb_size), 32'd2);
        check("rd_prot", 32'(freeahb_prot), 32'h3);
        freeahb_next = 1'b1;
        tick();
        freeahb_next = 1'b0;
        tick();
        check("rd_hold_valid", 32'(freeahb_valid), 32'd1);
        check("rd_hold_ready", 32'(mem_ready), 32'd0);
        freeahb_ready = 1'b1;
        freeahb_rdata = 32'hAAAA_FFFF;
        tick();
        freeahb_ready = 1'b0;
        freeahb_rdata = 32'h1234_5678;
        check("rd_done", 32'(mem_ready), 32'd1);
        check("rd_data", mem_rdata, 32'hAAAA_FFFF);
        check("rd_drop", 32'(freeahb_valid), 32'd0);
        mem_valid = 1'b0;
        tick();
        check("rd_pulse", 32'(mem_ready), 32'd0);
        check("rd_keep", mem_rdata, 32'hAAAA_FFFF);

        // Halfword write from a fetch context; mem_valid drops mid-way.
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        mem_wdata = 32'hF0FF_0FAA;
        mem_wstrb = 4'b1100;
        mem_instr = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("hw_wr", 32'(freeahb_write), 32'd1);
        check("hw_rd", 32'(freeahb_read), 32'd0);
        check("hw_addr", freeahb_addr, 32'h8000_0002);
        check("hw_size", 32'(freeahb_size), 32'd1);
        check("hw_wdata", freeahb_wdata, 32'hF0FF_0FAA);
        check("hw_prot", 32'(freeahb_prot), 32'h2);
        freeahb_ready = 1'b1;
        tick();
        freeahb_ready = 1'b0;
        check("hw_hold_valid", 32'(freeahb_valid), 32'd1);
        check("hw_hold_ready", 32'(mem_ready), 32'd0);
        freeahb_next = 1'b1;
        tick();
        freeahb_next = 1'b0;
        check("hw_done", 32'(mem_ready), 32'd1);
        check("hw_drop", 32'(freeahb_valid), 32'd0);
        tick();
        check("hw_pulse", 32'(mem_ready), 32'd0);

        do_write("b2", 32'h1000_0000, 4'b0100, 32'h1000_0002, 3'b000);
        do_write("b1", 32'h1000_0010, 4'b0010, 32'h1000_0011, 3'b000);
        do_write("b3", 32'h1000_0023, 4'b1000, 32'h1000_0023, 3'b000);
        do_write("b0", 32'h1000_0033, 4'b0001, 32'h1000_0030, 3'b000);
        do_write("w", 32'h2000_0004, 4'b1111, 32'h2000_0004, 3'b010);
        do_write("odd", 32'h3000_000A, 4'b0110, 32'h3000_0008, 3'b010);
        do_write("h0", 32'h4000_000F, 4'b0011, 32'h4000_000C, 3'b001);

        // Back-to-back: mem_valid stays high through TURN.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0100;
        mem_wstrb = 4'd0;
        mem_instr = 1'b1;
        tick();
        check("bb_prot", 32'(freeahb_prot), 32'h2);
        freeahb_ready = 1'b1;
        freeahb_rdata = 32'h0BAD_F00D;
        tick();
        freeahb_ready = 1'b0;
        check("bb_done", 32'(mem_ready), 32'd1);
        mem_addr = 32'h0000_0204;
        tick();
        check("bb_turn_valid", 32'(freeahb_valid), 32'd0);
        check("bb_turn_ready", 32'(mem_ready), 32'd0);
        tick();
        check("bb_next_valid", 32'(freeahb_valid), 32'd1);
        check("bb_next_addr", freeahb_addr, 32'h0000_0204);

        // Abort a read with reset while data is offered.
        freeahb_ready = 1'b1;
        resetn        = 1'b1;
        #1;
        check("ab_valid", 32'(freeahb_valid), 32'd0);
        tick();
        check("ab_ready", 32'(mem_ready), 32'd0);
        check("ab_rdata", mem_rdata, 32'd0);
        freeahb_ready = 1'b0;
        mem_valid     = 1'b0;
        resetn        = 1'b0;
        tick();
        tick();
        check("ab_idle_valid", 32'(freeahb_valid), 32'd0);
        check("ab_idle_ready", 32'(mem_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
